// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: circular byte FIFO feeding a UART transmitter, one frame at a time.
// Ports: clk, reset (async, active-high); wr_en/wr_data push side with full/empty/count/overflow;
//        tx_start/tx_data to the transmitter, tx_done_tick from it; busy while a frame is owned.
module uart_tx_feeder #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done_tick,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_nx;
    logic              push, pop;

    // Full is the registered flag, so a same-cycle pop never frees room
    // for a write.
    assign push = wr_en && !full;
    assign busy = (state != S_IDLE);

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = S_LAUNCH;
                end
            end
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT: begin
                if (tx_done_tick) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        count_nx = count;
        if (push && !pop) count_nx = count + 1'b1;
        else if (pop && !push) count_nx = count - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_nx;
            count    <= count_nx;
            full     <= (count_nx == FULL_CNT);
            empty    <= (count_nx == '0);
            overflow <= wr_en && full;
            // Registered off LAUNCH: the pulse lands one cycle after the
            // pop, while tx_data is already stable.
            tx_start <= (state == S_LAUNCH);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                tx_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage carries no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: randomized bench for uart_tx_feeder against a queue-based
// reference model, with a simple transmitter that answers each tx_start.
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full, empty, overflow, tx_start, busy;
    logic [4:0] count;
    logic [7:0] tx_data;
    logic       tx_done_tick;

    uart_tx_feeder #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_done_tick(tx_done_tick),
        .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [17:0] RST_VEC = {5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    logic [17:0] dut_vec;
    assign dut_vec = {count, full, empty, overflow, tx_start, tx_data, busy};

    int vectors = 0;
    int miscompares = 0;

    // Reference model: bytes waiting in the FIFO, and the byte owned by
    // the transmitter side (busy, edges since it was taken from the FIFO).
    logic [7:0]  m_q[$];
    logic [7:0]  dut_sent[$];
    logic        m_busy, m_ov, m_start;
    int          m_age;
    logic [7:0]  m_tx;
    logic [17:0] m_vec;
    int          cd;
    int          fix_len;
    logic        rnd_len;

    task automatic model_reset();
        m_q.delete();
        m_busy = 1'b0;
        m_age = 0;
        m_ov = 1'b0;
        m_start = 1'b0;
        m_tx = 8'h00;
        cd = 0;
        m_vec = RST_VEC;
    endtask

    // One clock: update the model from the inputs seen at the edge, then
    // drive the transmitter reply for the following cycle.
    task automatic cyc();
        logic w, t, auto_tick;
        logic [7:0] d;
        int sz;
        @(posedge clk);
        w = wr_en;
        d = wr_data;
        t = tx_done_tick;
        sz = m_q.size();
        m_ov = w && (sz == 16);
        if (m_busy) begin
            if (t && m_age >= 1) m_busy = 1'b0;
            else m_age++;
        end else if (sz > 0) begin
            m_tx = m_q.pop_front();
            m_busy = 1'b1;
            m_age = 0;
        end
        if (w && sz < 16) m_q.push_back(d);
        m_start = m_busy && (m_age == 1);
        m_vec = {5'(m_q.size()), (m_q.size() == 16), (m_q.size() == 0),
                 m_ov, m_start, m_tx, m_busy};
        #1;
        if (tx_start) dut_sent.push_back(tx_data);
        wr_en = 1'b0;
        auto_tick = 1'b0;
        if (m_start) begin
            cd = rnd_len ? int'($urandom_range(1, 10)) : fix_len;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) auto_tick = 1'b1;
        end
        tx_done_tick = auto_tick;
    endtask

    task automatic drain(input string name, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            cyc();
            vectors++;
            if (dut_vec !== m_vec) begin
                miscompares++;
                $display("FAIL %s_drain: got %h expected %h", name, dut_vec, m_vec);
            end
            if (m_q.size() == 0 && !m_busy) done = 1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, budget);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (dut_vec !== RST_VEC) begin
            miscompares++;
            $display("FAIL reset_held: got %h expected %h", dut_vec, RST_VEC);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            vectors++;
            if (dut_vec !== RST_VEC) begin
                miscompares++;
                $display("FAIL reset_idle: got %h expected %h", dut_vec, RST_VEC);
            end
        end
    endtask

    task automatic test_single();
        int starts = 0;
        rnd_len = 1'b0;
        fix_len = 160;
        wr_en = 1'b1;
        wr_data = 8'hA5;
        cyc();
        cyc();
        vectors++;
        if (tx_start !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early: got tx_start %b expected 0", tx_start);
        end
        cyc();
        vectors++;
        if ({tx_start, tx_data} !== {1'b1, 8'hA5}) begin
            miscompares++;
            $display("FAIL single_start: got %b/%h expected 1/a5", tx_start, tx_data);
        end
        for (int i = 0; i < 160; i++) begin
            cyc();
            if (tx_start) starts++;
        end
        vectors++;
        if ({starts, busy} !== {32'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL single_frame: got starts %0d busy %b expected 0/1", starts, busy);
        end
        cyc();
        vectors++;
        if ({busy, empty} !== 2'b01) begin
            miscompares++;
            $display("FAIL single_busy_fall: got busy %b empty %b expected 0/1", busy, empty);
        end
    endtask

    task automatic test_burst();
        dut_sent.delete();
        rnd_len = 1'b0;
        fix_len = 200;
        wr_en = 1'b1;
        wr_data = 8'h5A;
        cyc();
        cyc();
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            cyc();
        end
        vectors++;
        if ({full, count} !== {1'b1, 5'd16}) begin
            miscompares++;
            $display("FAIL burst_full: got full %b count %0d expected 1/16", full, count);
        end
        wr_en = 1'b1;
        wr_data = 8'hFF;
        cyc();
        vectors++;
        if ({overflow, count} !== {1'b1, 5'd16}) begin
            miscompares++;
            $display("FAIL burst_ovf: got ovf %b count %0d expected 1/16", overflow, count);
        end
        fix_len = 20;
        cyc();
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_ovf_pulse: got %b expected 0", overflow);
        end
        drain("burst", 1500);
        vectors++;
        if (dut_sent.size() != 17) begin
            miscompares++;
            $display("FAIL burst_len: got %0d frames expected 17", dut_sent.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                logic [7:0] e;
                e = (i == 0) ? 8'h5A : 8'(i);
                vectors++;
                if (dut_sent[i] !== e) begin
                    miscompares++;
                    $display("FAIL burst_order[%0d]: got %h expected %h", i, dut_sent[i], e);
                end
            end
        end
    endtask

    task automatic test_wrap();
        rnd_len = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wr_en = 1'b1;
            wr_data = 8'($urandom);
            cyc();
            vectors++;
            if (dut_vec !== m_vec) begin
                miscompares++;
                $display("FAIL wrap: got %h expected %h", dut_vec, m_vec);
            end
        end
        drain("wrap", 3000);
    endtask

    task automatic test_spurious();
        rnd_len = 1'b1;
        for (int i = 0; i < 400; i++) begin
            wr_en = ($urandom_range(0, 3) == 0);
            wr_data = 8'($urandom);
            if ((!m_busy || m_age == 0) && $urandom_range(0, 1) == 1)
                tx_done_tick = 1'b1;
            cyc();
            vectors++;
            if (dut_vec !== m_vec) begin
                miscompares++;
                $display("FAIL spurious: got %h expected %h", dut_vec, m_vec);
            end
        end
        drain("spurious", 3000);
    endtask

    task automatic test_reset_wait();
        rnd_len = 1'b0;
        fix_len = 300;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            wr_data = 8'($urandom);
            cyc();
        end
        vectors++;
        if ({count, busy} !== {5'd5, 1'b1}) begin
            miscompares++;
            $display("FAIL rstw_queued: got count %0d busy %b expected 5/1", count, busy);
        end
        #2 reset = 1'b1;
        model_reset();
        tx_done_tick = 1'b0;
        #1;
        vectors++;
        if (dut_vec !== RST_VEC) begin
            miscompares++;
            $display("FAIL rstw_async: got %h expected %h", dut_vec, RST_VEC);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            vectors++;
            if (dut_vec !== RST_VEC) begin
                miscompares++;
                $display("FAIL rstw_quiet: got %h expected %h", dut_vec, RST_VEC);
            end
        end
        rnd_len = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h3C;
        cyc();
        cyc();
        cyc();
        vectors++;
        if ({tx_start, tx_data} !== {1'b1, 8'h3C}) begin
            miscompares++;
            $display("FAIL rstw_new: got %b/%h expected 1/3c", tx_start, tx_data);
        end
        drain("rstw", 100);
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        tx_done_tick = 1'b0;
        rnd_len = 1'b0;
        fix_len = 10;
        model_reset();
        #1;
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_spurious();
        test_reset_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
